uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state names, default
// oversampling factor and the baud divider calculation.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int OVERSAMPLE_DEFAULT = 16;

  // round(clk_hz / (baud * oversample)), never below 1
  function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
    longint den;
    longint q;
    den = longint'(baud) * longint'(oversample);
    q   = (longint'(clk_hz) + den / 2) / den;
    return (q < 1) ? 1 : int'(q);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick divider: tick is high one cycle in every DIV; restart
// realigns the count so the next tick lands DIV cycles later.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled mid-bit sampling, a one-entry holding
// register, frame error pulse and sticky overrun flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 16_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rxd,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        frame_err,
  output logic        overrun,
  output uart_state_e rx_state
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int TW  = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

  logic [1:0]    sync;
  logic          rxs;
  logic          rxs_d;
  logic          fall_edge;
  logic          restart;
  logic          tick;
  uart_state_e   state;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;

  assign rxs       = sync[1];
  // Edge-triggered start: after a low stop bit the line must go high again
  // before a new frame can begin.
  assign fall_edge = rxs_d & ~rxs;
  assign restart   = (state == IDLE) && fall_edge;
  assign rx_state  = state;

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  // Handshake: rx_data is offered while rx_valid=1 and is consumed on any
  // clock where rx_valid and rx_ready are both 1; a byte completing in that
  // same clock replaces it and rx_valid stays high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= 2'b11;
      rxs_d     <= 1'b1;
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync      <= {sync[0], uart_rxd};
      rxs_d     <= rxs;
      frame_err <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (fall_edge) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == MID_TICK) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rxs ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt <= '0;
              shift    <= {rxs, shift[7:1]};
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) state <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt <= '0;
              state    <= IDLE;
              if (!rxs) begin
                frame_err <= 1'b1;
              end else if (!rx_valid || rx_ready) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: directed frames plus a random
// frame stream, checked against an expected-byte queue every cycle.
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_HZ   = 16_000_000;
  localparam int BAUD     = 1_000_000;
  localparam int OS       = 16;
  localparam int BIT_CLKS = CLK_HZ / BAUD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rxd = 1'b1;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        overrun;
  uart_state_e rx_state;

  logic ready_rand = 1'b0;
  logic ready_fixed = 1'b1;
  logic ready_rnd_bit = 1'b1;
  assign rx_ready = ready_rand ? ready_rnd_bit : ready_fixed;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // behavioural model state
  logic [7:0] exp_q[$];
  int         err_pending = 0;
  logic       overrun_allowed = 1'b0;
  int         valid_rises = 0;
  int         err_pulses = 0;
  int         last_rise_cyc = 0;
  int         frame_start_cyc = 0;
  logic [7:0] last_hs_data = 8'h00;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic       prev_err = 1'b0;
  logic       prev_ovr = 1'b0;
  logic [7:0] prev_data = 8'h00;

  uart_rx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rxd  (uart_rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_state  (rx_state)
  );

  // clock / reset block
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    ready_rnd_bit = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // scoreboard / compare process
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got %0h expected none", rx_data);
        end else begin
          check("rx_data_handshake", rx_data, exp_q.pop_front());
        end
        last_hs_data = rx_data;
      end
      if (rx_valid && !prev_valid) begin
        valid_rises++;
        last_rise_cyc = cyc;
      end
      if (frame_err) begin
        err_pulses++;
        check("frame_err_width", prev_err, 0);
        if (err_pending == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame_err: got 1 expected 0");
        end else begin
          err_pending--;
        end
      end
      if (prev_valid && !prev_ready && rx_valid) check("rx_data_stable", rx_data, prev_data);
      if (!overrun_allowed) check("overrun_clear", overrun, 0);
      else if (prev_ovr) check("overrun_sticky", overrun, 1);
    end
    prev_valid = rx_valid;
    prev_ready = rx_ready;
    prev_err   = frame_err;
    prev_ovr   = overrun;
    prev_data  = rx_data;
  end

  // driver tasks (entered just after a rising edge)
  task automatic drive_bit(input logic v);
    uart_rxd = v;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic deliver);
    if (!stop) err_pending++;
    else if (deliver) exp_q.push_back(b);
    frame_start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    exp_q.delete();
    err_pending = 0;
    @(posedge clk);
    #1;
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state", rx_state, IDLE);
    overrun_allowed = 1'b0;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || err_pending != 0) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, exp_q.size() + err_pending, 0);
  endtask

  initial begin
    int r0;
    int e0;
    logic [7:0] part;
    logic [7:0] b;
    logic bad;
    int g;

    repeat (3) @(posedge clk);
    #1;
    pulse_reset();
    idle(10);

    // single frame, latency from start edge
    r0 = valid_rises;
    send_frame(8'h55, 1'b1, 1'b1);
    idle(4);
    check_range("latency_55", last_rise_cyc - frame_start_cyc, 153, 156);
    check("rises_55", valid_rises - r0, 1);
    check("data_55", last_hs_data, 8'h55);
    wait_drain("drain_55");

    // back-to-back frames with no idle gap
    r0 = valid_rises;
    send_frame(8'hA5, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(4);
    check("rises_b2b", valid_rises - r0, 2);
    check("data_3c", last_hs_data, 8'h3C);
    wait_drain("drain_b2b");

    // short glitch on idle line
    r0 = valid_rises;
    e0 = err_pulses;
    uart_rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    uart_rxd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("glitch_in_start", rx_state, START);
    idle(30);
    check("glitch_back_idle", rx_state, IDLE);
    check("glitch_no_valid", valid_rises - r0, 0);
    check("glitch_no_err", err_pulses - e0, 0);

    // stop bit low, then a good frame
    r0 = valid_rises;
    e0 = err_pulses;
    send_frame(8'hF0, 1'b0, 1'b0);
    idle(8);
    check("ferr_pulses", err_pulses - e0, 1);
    check("ferr_no_valid", valid_rises - r0, 0);
    send_frame(8'h12, 1'b1, 1'b1);
    idle(4);
    check("data_12", last_hs_data, 8'h12);
    wait_drain("drain_ferr");

    // overrun with consumer stalled
    ready_fixed = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1);
    overrun_allowed = 1'b1;
    send_frame(8'h22, 1'b1, 1'b0);
    idle(4);
    check("ovr_valid_held", rx_valid, 1);
    check("ovr_data_kept", rx_data, 8'h11);
    check("ovr_flag", overrun, 1);
    ready_fixed = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_valid_cleared", rx_valid, 0);
    check("ovr_still_set", overrun, 1);
    check("ovr_hs_data", last_hs_data, 8'h11);
    check("ovr_queue_empty", exp_q.size(), 0);
    idle(4);

    // reset during bit 4 of a frame
    part = 8'h99;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(part[i]);
    uart_rxd = part[4];
    repeat (8) @(posedge clk);
    #1;
    check("mid_frame_state", rx_state, DATA);
    r0 = valid_rises;
    e0 = err_pulses;
    pulse_reset();
    idle(150);
    check("rst_frame_no_valid", valid_rises - r0, 0);
    check("rst_frame_no_err", err_pulses - e0, 0);
    send_frame(8'h66, 1'b1, 1'b1);
    idle(4);
    check("data_66", last_hs_data, 8'h66);
    wait_drain("drain_rst");

    // random frame stream with random consumer stalls
    ready_rand = 1'b1;
    for (int k = 0; k < 24; k++) begin
      b   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 5) == 0);
      send_frame(b, !bad, 1'b1);
      g = $urandom_range(0, 12);
      if (bad && g < 2) g = 2;
      if (g > 0) idle(g);
    end
    idle(4);
    wait_drain("drain_random");
    ready_rand = 1'b0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
